muldiv: RTL and testbench
=========================

Name: muldiv

Overview:
Iterative, parametrised multiply/divide unit, the multi-cycle companion to the combinational ALU. Implements the eight RV32M operations. Used by the execute stage through a start/busy/done handshake. Operands and results are N bits wide. Adds signedness handling, RISC-V divide special cases and pipeline-flush abort, none of which the ALU has.

Parameters:
N, 32, operand/result width in bits (N >= 4; counter width = clog2(N)+1)

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-low reset
START  in  1  request; sampled only while in IDLE
OP  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
A  in  N  operand 1 (dividend / multiplicand); captured with START
B  in  N  operand 2 (divisor / multiplier); captured with START
KILL  in  1  abort in-flight operation (pipeline flush)
BUSY  out  1  operation in flight (state RUN or FIN)
DONE  out  1  one-cycle pulse; RESULT valid this cycle
RESULT  out  N  registered result; held until next DONE
ZERO  out  1  registered, equals (RESULT == 0)

Behaviour:
- Reset (reset=0 at an edge): state IDLE, BUSY=0, DONE=0, RESULT=0, ZERO=1, counter=0. Applies mid-operation; the operation is discarded.
- States: IDLE, RUN, FIN. Priority at each edge: reset > KILL > normal.
- IDLE, START=1, KILL=0: latch OP, |A|, |B| (signed ops only; MULHSU: A signed, B unsigned), result-sign and remainder-sign flags. Next state RUN, counter=0.
- Special cases detected in IDLE go straight to FIN and skip RUN:
  - Divisor zero: DIV/DIVU -> all ones; REM/REMU -> A.
  - Signed overflow (A = 1<<(N-1), B = all ones): DIV -> A; REM -> 0.
- RUN, multiply: shift-add, one multiplier bit per cycle, 2N-bit accumulator.
- RUN, divide: restoring division, one quotient bit per cycle.
- RUN lasts exactly N edges; the edge where counter reaches N-1 moves to FIN.
- FIN: conditionally negate (two's complement, N or 2N bits) and select:
  - MUL: low N bits.
  - MULH*: high N bits.
  - Signed quotient: negated if operand signs differ.
  - Signed remainder: takes the sign of the dividend.
  - Register RESULT and ZERO, DONE=1 for one cycle, next state IDLE.
- Latency: START accepted at edge k -> DONE high after edge k+N+1 (33 cycles for N=32). Special cases: DONE after edge k+1.
- BUSY=1 after edges k+1 .. k+N (or only after k for special cases). BUSY=0 in the DONE cycle.
- START while BUSY is ignored; no queueing.
- START in the DONE cycle is accepted (back-to-back issue); no bubble.
- KILL=1 while BUSY: next edge -> IDLE. DONE stays 0; RESULT/ZERO unchanged.
- KILL together with START in IDLE: START dropped.
- KILL in IDLE alone: no effect.
- KILL on the edge that would register FIN: the kill wins and no DONE is produced.
- Operand inputs may change freely after the START edge.
- No X propagation: all registers have a reset value; OP has no illegal encodings.

Decomposition:
- Shared package muldiv_pkg: localparams for the eight OP encodings, state encoding (IDLE/RUN/FIN), and helpers is_div(op) / is_signed_a(op) / is_signed_b(op).
- One natural sub-module: muldiv_step, the combinational single-iteration datapath (shift-add or restore-subtract selected by mode), instantiated once.
- Control FSM and sign fixup stay in muldiv.

Test Plan:
1. N=32 MUL A=00000007 B=FFFFFFFD -> RESULT=FFFFFFEB, ZERO=0. DONE exactly 33 edges after the START edge; BUSY high for 32 cycles, low in the DONE cycle.
2. High-word multiplies:
   - MULH 80000000*80000000 -> 40000000.
   - MULHU FFFFFFFF*FFFFFFFF -> FFFFFFFE.
   - MULHSU FFFFFFFF*FFFFFFFF -> FFFFFFFF.
   - MUL 0*1234 -> 0, ZERO=1.
3. Divides:
   - DIV FFFFFFF9/00000002 -> FFFFFFFD; REM same operands -> FFFFFFFF.
   - DIVU 00000064/00000007 -> 0000000E; REMU same operands -> 00000002.
   - Issue back-to-back, START in each DONE cycle, with no gap.
4. Special cases, each with DONE one edge after START:
   - DIVU 5/0 -> FFFFFFFF; REM 5/0 -> 00000005.
   - DIV 80000000/FFFFFFFF -> 80000000; REM same operands -> 0, ZERO=1.
5. Abort and ignore rules:
   - Prior RESULT=0000ABCD; start DIV, assert KILL on the 10th RUN cycle -> IDLE next edge, no DONE, RESULT stays 0000ABCD.
   - START pulses while BUSY are ignored.
   - KILL+START in IDLE -> no operation.
6. Reset low mid-RUN -> BUSY=0, DONE=0, RESULT=0, ZERO=1 after that edge.
   - Rerun with N=8: MULHU FF*FF -> FE, DIV 80/FF -> 80, DONE 9 edges after START.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, control state encoding and operand-signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // MUL produces identical low bits either way, so it runs unsigned.
  function automatic logic is_signed_a(input logic [2:0] op);
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM:  return 1'b1;
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU:  return 1'b0;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    case (op)
      OP_MULH, OP_DIV, OP_REM: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the muldiv datapath: shift-add multiply step or
// restoring-divide step on a {high, low} 2N-bit accumulator.
module muldiv_step #(
  parameter int N = 32
) (
  input  logic           div_mode,
  input  logic [2*N-1:0] acc,
  input  logic [N-1:0]   opnd,
  output logic [2*N-1:0] acc_next
);

  logic [N:0]   sum;
  logic [N:0]   shifted;
  logic [N-1:0] diff;

  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    // Multiply: low half holds the remaining multiplier bits, LSB first.
    sum      = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: high half is the partial remainder, low half the dividend/quotient.
    shifted  = acc[2*N-1:N-1];
    diff     = shifted[N-1:0] - opnd;
    acc_next = {sum, acc[N-1:1]};
    if (div_mode) begin
      if (shifted >= {1'b0, opnd}) acc_next = {diff, acc[N-2:0], 1'b1};
      else                         acc_next = {shifted[N-1:0], acc[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake,
// sign fixup, RISC-V divide special cases and flush abort.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         START,
  input  logic [2:0]   OP,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         KILL,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] RESULT,
  output logic         ZERO
);

  localparam int CW = $clog2(N) + 1;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [2:0]     op_q;
  logic           neg_q;
  logic           spec_q;
  logic [N-1:0]   opnd_q;
  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] acc_next;

  logic           a_neg, b_neg, neg_in, div_zero, ovf, special;
  logic [N-1:0]   a_mag, b_mag, spec_val;
  logic [2*N-1:0] prod;
  logic [N-1:0]   div_val, fin_res;

  muldiv_step #(.N(N)) u_step (
    .div_mode (is_div(op_q)),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (acc_next)
  );

  // Operand capture and special-case detection, evaluated while IDLE.
  always_comb begin
    a_neg    = is_signed_a(OP) & A[N-1];
    b_neg    = is_signed_b(OP) & B[N-1];
    a_mag    = a_neg ? -A : A;
    b_mag    = b_neg ? -B : B;
    neg_in   = is_rem(OP) ? a_neg : (a_neg ^ b_neg);
    div_zero = (B == '0);
    ovf      = (OP == OP_DIV || OP == OP_REM) &&
               (A == {1'b1, {(N-1){1'b0}}}) && (B == '1);
    special  = is_div(OP) && (div_zero || ovf);
    if (div_zero) spec_val = is_rem(OP) ? A : '1;
    else          spec_val = is_rem(OP) ? '0 : A;
  end

  // Final sign fixup and result selection.
  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    div_val = is_rem(op_q) ? acc_q[2*N-1:N] : acc_q[N-1:0];
    if (spec_q)              fin_res = acc_q[N-1:0];
    else if (is_div(op_q))   fin_res = neg_q ? -div_val : div_val;
    else if (op_q == OP_MUL) fin_res = prod[N-1:0];
    else                     fin_res = prod[2*N-1:N];
  end

  // The acceptance cycle (RUN, cnt 0) does not count as busy, so BUSY spans
  // exactly N cycles for a full operation and one for a special case.
  assign BUSY = (state == ST_FIN) || (state == ST_RUN && cnt != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_q   <= OP_MUL;
      neg_q  <= 1'b0;
      spec_q <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
      DONE   <= 1'b0;
      RESULT <= '0;
      ZERO   <= 1'b1;
    end else begin
      DONE <= 1'b0;
      if (KILL) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: if (START) begin
            op_q   <= OP;
            neg_q  <= neg_in;
            spec_q <= special;
            cnt    <= '0;
            opnd_q <= is_div(OP) ? b_mag : a_mag;
            if (special) begin
              acc_q <= {{N{1'b0}}, spec_val};
              state <= ST_FIN;
            end else begin
              acc_q <= {{N{1'b0}}, (is_div(OP) ? a_mag : b_mag)};
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            acc_q <= acc_next;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) state <= ST_FIN;
          end
          ST_FIN: begin
            RESULT <= fin_res;
            ZERO   <= (fin_res == '0);
            DONE   <= 1'b1;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: back-to-back vector table with a result
// scoreboard, plus abort, ignore, reset and narrow-width sequences.
module tb_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        START, KILL;
  logic [2:0]  OP;
  logic [31:0] A, B, RESULT;
  logic        BUSY, DONE, ZERO;

  logic        START8, KILL8;
  logic [2:0]  OP8;
  logic [7:0]  A8, B8, RESULT8;
  logic        BUSY8, DONE8, ZERO8;

  muldiv #(.N(32)) dut (
    .clk(clk), .reset(reset), .START(START), .OP(OP), .A(A), .B(B),
    .KILL(KILL), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .ZERO(ZERO)
  );

  muldiv #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .START(START8), .OP(OP8), .A(A8), .B(B8),
    .KILL(KILL8), .BUSY(BUSY8), .DONE(DONE8), .RESULT(RESULT8), .ZERO(ZERO8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [32:0] sb[$];   // {ZERO, RESULT} expected at each DONE
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every DONE must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && DONE) begin
      check("done_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) check("sb_result", 64'({ZERO, RESULT}), 64'(sb.pop_front()));
    end
  end

  // Called at a negedge where the DUT is idle or in its DONE cycle; returns
  // at the negedge where DONE is seen, so consecutive calls issue back-to-back.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat_exp, input string name,
                        input bit poke);
    int lat, busy_n;
    START = 1'b1; OP = op; A = a; B = b;
    sb.push_back({(res == 32'd0), res});
    @(negedge clk);
    START = 1'b0; OP = 3'($urandom); A = $urandom; B = $urandom;
    if (poke) begin OP = OP_DIVU; B = 32'd0; end
    lat = 0; busy_n = 0;
    while (!DONE && lat < 100) begin
      if (BUSY) busy_n++;
      if (poke) START = (lat == 5 || lat == 20 || lat == 32);
      @(negedge clk);
      lat++;
    end
    START = 1'b0;
    check({name, "_lat"}, 64'(lat), 64'(lat_exp));
    check({name, "_busy_cycles"}, 64'(busy_n), 64'((lat_exp == 1) ? 1 : lat_exp - 1));
    check({name, "_busy_in_done"}, 64'(BUSY), 64'd0);
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] res, input int lat_exp, input string name);
    int lat;
    START8 = 1'b1; OP8 = op; A8 = a; B8 = b;
    @(negedge clk);
    START8 = 1'b0; A8 = 8'($urandom); B8 = 8'($urandom);
    lat = 0;
    while (!DONE8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(lat_exp));
    check({name, "_res"}, 64'(RESULT8), 64'(res));
    check({name, "_zero"}, 64'(ZERO8), 64'(res == 8'd0));
  endtask

  initial begin
    logic [31:0] ra, rb;
    int dones;

    vecs.push_back('{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7_m3"});
    vecs.push_back('{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_min"});
    vecs.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max"});
    vecs.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu_m1"});
    vecs.push_back('{OP_MUL,    32'h00000000, 32'h00001234, 32'h00000000, 33, "mul_zero"});
    vecs.push_back('{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, "mulh_m1_m1"});
    vecs.push_back('{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, "div_m7_2"});
    vecs.push_back('{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, "rem_m7_2"});
    vecs.push_back('{OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, "div_7_m2"});
    vecs.push_back('{OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33, "rem_7_m2"});
    vecs.push_back('{OP_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 33, "divu_100_7"});
    vecs.push_back('{OP_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 33, "remu_100_7"});
    vecs.push_back('{OP_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1,  "divu_by0"});
    vecs.push_back('{OP_REM,    32'h00000005, 32'h00000000, 32'h00000005, 1,  "rem_by0"});
    vecs.push_back('{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf"});
    vecs.push_back('{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "rem_ovf"});
    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom | 32'h1;
      vecs.push_back('{OP_MULHU, ra, rb, 32'((64'(ra) * 64'(rb)) >> 32), 33, "rnd_mulhu"});
      vecs.push_back('{OP_DIVU,  ra, rb >> 8, ra / (rb >> 8), 33, "rnd_divu"});
      vecs.push_back('{OP_REMU,  ra, rb >> 4, ra % (rb >> 4), 33, "rnd_remu"});
    end

    reset = 1'b0; START = 1'b0; KILL = 1'b0; OP = OP_MUL; A = '0; B = '0;
    START8 = 1'b0; KILL8 = 1'b0; OP8 = OP_MUL; A8 = '0; B8 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   64'(BUSY),   64'd0);
    check("rst_done",   64'(DONE),   64'd0);
    check("rst_result", 64'(RESULT), 64'd0);
    check("rst_zero",   64'(ZERO),   64'd1);
    check("rst8_busy",  64'(BUSY8),  64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Whole table issued back-to-back, each START in the previous DONE cycle.
    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                             vecs[i].lat, vecs[i].name, 1'b0);

    // START pulses during RUN and FIN must not disturb the operation.
    run_op(OP_MULHU, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E, 33, "busy_ignore", 1'b1);

    // Abort: prior RESULT must survive a kill on the 10th RUN cycle.
    run_op(OP_MUL, 32'h00000001, 32'h0000ABCD, 32'h0000ABCD, 33, "mul_abcd", 1'b0);
    START = 1'b1; OP = OP_DIV; A = 32'h00001000; B = 32'h00000003;
    @(negedge clk);
    START = 1'b0;
    repeat (9) @(negedge clk);
    KILL = 1'b1;
    @(negedge clk);
    KILL = 1'b0;
    check("kill_busy",   64'(BUSY),   64'd0);
    check("kill_done",   64'(DONE),   64'd0);
    check("kill_result", 64'(RESULT), 64'h0000ABCD);
    check("kill_zero",   64'(ZERO),   64'd0);

    // KILL with START in IDLE drops the request; KILL alone in IDLE is harmless.
    START = 1'b1; KILL = 1'b1; OP = OP_DIVU; A = 32'd5; B = 32'd0;
    @(negedge clk);
    START = 1'b0; KILL = 1'b0;
    check("killstart_busy", 64'(BUSY), 64'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      KILL = (c == 3);
      @(negedge clk);
      if (DONE) dones++;
    end
    KILL = 1'b0;
    check("quiet_after_kill", 64'(dones), 64'd0);
    check("quiet_result", 64'(RESULT), 64'h0000ABCD);

    // Kill on the edge that would register FIN: no DONE.
    START = 1'b1; OP = OP_MUL; A = 32'd3; B = 32'd5;
    @(negedge clk);
    START = 1'b0;
    repeat (32) @(negedge clk);
    check("fin_busy_before_kill", 64'(BUSY), 64'd1);
    KILL = 1'b1;
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      KILL = 1'b0;
      if (DONE) dones++;
    end
    check("kill_at_fin_no_done", 64'(dones), 64'd0);
    check("kill_at_fin_result",  64'(RESULT), 64'h0000ABCD);

    // Reset mid-RUN discards the operation and clears the outputs.
    START = 1'b1; OP = OP_MULHU; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    @(negedge clk);
    START = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst_busy",   64'(BUSY),   64'd0);
    check("midrst_done",   64'(DONE),   64'd0);
    check("midrst_result", 64'(RESULT), 64'd0);
    check("midrst_zero",   64'(ZERO),   64'd1);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (DONE) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);

    // Narrow instance.
    run8(OP_MULHU, 8'hFF, 8'hFF, 8'hFE, 9, "n8_mulhu");
    run8(OP_DIV,   8'h80, 8'hFF, 8'h80, 1, "n8_div_ovf");
    run8(OP_DIVU,  8'hC8, 8'h0D, 8'h0F, 9, "n8_divu");
    run8(OP_REM,   8'hF9, 8'h02, 8'hFF, 9, "n8_rem");

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
